// File: rtl/block_exp_unit.sv
// Block-floating-point exponent detector: tracks the minimum sign-extension headroom
// across one AXI-stream frame and emits the shift code for the next FFT stage.
module block_exp_unit #(
  parameter int WIDTH     = 8,
  parameter int SHAMTBITS = 4,
  parameter int N_SAMPLES = 16,
  parameter int CNTBITS   = $clog2(N_SAMPLES) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic [WIDTH-1:0]     data_i,
  output logic [SHAMTBITS-1:0] shamt_o,
  output logic                 shamt_valid_o,
  input  logic                 shamt_ready_i,
  output logic                 len_err_o,
  output logic                 busy_o
);

  localparam int                   HBITS   = $clog2(WIDTH);
  localparam logic [HBITS-1:0]     H_MAX   = HBITS'(WIDTH - 1);
  localparam logic [SHAMTBITS-2:0] L_CAP   = '1;
  localparam logic [CNTBITS-1:0]   CNT_MAX = '1;
  localparam logic [CNTBITS-1:0]   CNT_EXP = CNTBITS'(N_SAMPLES);

  if (!((WIDTH == 8 && SHAMTBITS == 4) || (WIDTH == 16 && SHAMTBITS == 5)) || (N_SAMPLES < 2))
  begin : g_param_err
    $fatal(1, "block_exp_unit: illegal WIDTH/SHAMTBITS pair or N_SAMPLES < 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNTBITS-1:0] cnt_r;
  logic [HBITS-1:0]   m_r;

  logic               beat_s;
  logic [HBITS-1:0]   h_s;
  logic [HBITS-1:0]   m_next_s;
  logic [CNTBITS-1:0] cnt_next_s;

  // Count of bits below the sign bit that still equal it.
  function automatic logic [HBITS-1:0] headroom(input logic [WIDTH-1:0] x);
    logic [HBITS-1:0] h;
    logic             run;
    h   = '0;
    run = 1'b1;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (run && (x[i] == x[WIDTH-1])) begin
        h = h + HBITS'(1);
      end else begin
        run = 1'b0;
      end
    end
    return h;
  endfunction

  // No headroom means the next butterfly would overflow, so shift right; otherwise keep one guard bit.
  function automatic logic [SHAMTBITS-1:0] encode(input logic [HBITS-1:0] m);
    logic [HBITS-1:0] mm1;
    mm1 = m - HBITS'(1);
    if (m == '0) begin
      return {1'b1, {(SHAMTBITS-1){1'b0}}};
    end else if (32'(mm1) > 32'(L_CAP)) begin
      return {1'b0, L_CAP};
    end else begin
      return {1'b0, (SHAMTBITS-1)'(mm1)};
    end
  endfunction

  // Per-beat headroom, running minimum and saturating beat count.
  always_comb begin
    beat_s     = s_axis_tvalid && s_axis_tready;
    h_s        = headroom(data_i);
    m_next_s   = m_r;
    cnt_next_s = cnt_r;
    if (h_s < m_r) begin
      m_next_s = h_s;
    end else begin
      m_next_s = m_r;
    end
    if (cnt_r == CNT_MAX) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + CNTBITS'(1);
    end
  end

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= S_IDLE;
      s_axis_tready <= 1'b0;
      shamt_o       <= '0;
      shamt_valid_o <= 1'b0;
      len_err_o     <= 1'b0;
      busy_o        <= 1'b0;
      cnt_r         <= '0;
      m_r           <= H_MAX;
    end else begin
      case (state_r)
        S_IDLE, S_ACC: begin
          if (beat_s) begin
            cnt_r  <= cnt_next_s;
            m_r    <= m_next_s;
            busy_o <= 1'b1;
            if (s_axis_tlast) begin
              state_r       <= S_HOLD;
              s_axis_tready <= 1'b0;
              shamt_valid_o <= 1'b1;
              shamt_o       <= encode(m_next_s);
              if (cnt_next_s != CNT_EXP) begin
                len_err_o <= 1'b1;
              end else begin
                len_err_o <= len_err_o;
              end
            end else begin
              state_r       <= S_ACC;
              s_axis_tready <= 1'b1;
            end
          end else begin
            s_axis_tready <= 1'b1;
          end
        end
        S_HOLD: begin
          if (shamt_ready_i) begin
            state_r       <= S_IDLE;
            s_axis_tready <= 1'b1;
            shamt_valid_o <= 1'b0;
            busy_o        <= 1'b0;
            cnt_r         <= '0;
            m_r           <= H_MAX;
          end else begin
            state_r       <= S_HOLD;
            s_axis_tready <= 1'b0;
          end
        end
        default: begin
          state_r       <= S_IDLE;
          s_axis_tready <= 1'b0;
          shamt_valid_o <= 1'b0;
          busy_o        <= 1'b0;
          cnt_r         <= '0;
          m_r           <= H_MAX;
        end
      endcase
    end
  end

endmodule
